phase_alu_sequencer: RTL
========================

Name: phase_alu_sequencer

Overview:
Downstream consumer of the 4-phase ring counter's one-hot outputs Phase0..Phase3. Runs one ALU operation per full phase rotation:
- Phase0: arm.
- Phase1: compute.
- Phase2: write result.
- Phase3: complete.

Accepts a Start request with operands, reports Busy/Done, and flags phase-sequence violations. Clocked by the same Phase_Count clock that drives the ring counter.

Parameters:
WIDTH, 8, operand/result width in bits (min 2)

Ports:
Phase_Count  input  1  clock; all state updates on rising edge
Clear  input  1  synchronous, active-low reset
Phase0  input  1  ring counter phase 0 (one-hot group)
Phase1  input  1  ring counter phase 1
Phase2  input  1  ring counter phase 2
Phase3  input  1  ring counter phase 3
Start  input  1  request; sampled only in IDLE
Op  input  2  00 ADD, 01 SUB, 10 AND, 11 XOR; captured with Start
Operand_A  input  WIDTH  first operand; captured with Start
Operand_B  input  WIDTH  second operand; captured with Start
Busy  output  1  high from ARMED through S3
Done  output  1  one-cycle completion pulse
Result  output  WIDTH  registered result; holds until next write
Carry  output  1  ADD carry-out / SUB borrow (A<B) / 0 for logic ops
Phase_Err  output  1  sticky phase-sequence error flag

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock port is Phase_Count and reset port is Clear.
- Reset (Clear=0 at an edge): state IDLE. Busy=0, Done=0, Result=0, Carry=0, Phase_Err=0. Captured Op/operands = 0.
- Reset mid-operation aborts at once. No Done pulse. Result/Carry are cleared.
- States: IDLE, ARMED, S1, S2, S3. Registered state, registered outputs.
- IDLE, Start=1:
  - Capture Op, Operand_A and Operand_B.
  - Clear Phase_Err.
  - Go to ARMED; Busy=1 from the next cycle.
- IDLE, Start=0: stay. Phases are ignored in IDLE.
- A Start coincident with Phase0 in IDLE does not count as the arming Phase0. The block waits for the next Phase0.
- ARMED: waits indefinitely.
  - Phase vector == 0001 (Phase0 only): go to S1.
  - Any other one-hot vector: stay.
- S1: Phase1-only required. Compute the operation into an internal temp; go to S2.
- S2: Phase2-only required. Write temp to Result/Carry; go to S3.
- S3: Phase3-only required. Go to IDLE with Done=1 for exactly that next cycle; Busy=0 in the same cycle.
- Latency: Phase0 seen at cycle t0 gives Result valid at t3 and Done=1 at t4.
- Start while Busy=1 is ignored; the captured operands are unaffected.
- Arithmetic is WIDTH-bit modulo:
  - ADD: Carry = bit WIDTH of A+B.
  - SUB: Result = A-B mod 2^WIDTH, Carry=1 iff A<B unsigned.
  - AND/XOR: Carry=0.
- Phase check, in any non-IDLE state: a vector that is not one-hot (zero or multiple bits), or the wrong phase in S1–S3, sets Phase_Err=1.
  - Go to IDLE with Busy=0 and no Done pulse.
  - Result/Carry are unchanged if the error occurs before the S2 write.
- Phase_Err holds until reset or the next accepted Start.
- Done and Phase_Err never assert in the same cycle.

Optional Feature:
Macro PHASE_CHECK_EN.
- Defined: phase validation exactly as above.
- Undefined:
  - Phase_Err is tied to 0.
  - ARMED advances on Phase0=1, ignoring the other bits.
  - S1, S2 and S3 each advance unconditionally after one cycle, with the same Result/Done timing.
  - Phase inputs other than Phase0 are unused.

Test Plan:
1. Reset, then Start with Op=00, A=8'hF0, B=8'h20; rotate phases 0→1→2→3 -> Result=8'h10, Carry=1 at t3; Done=1 for one cycle at t4; Busy falls at t4.
2. Op=01, A=8'h05, B=8'h07 -> Result=8'hFE, Carry=1. Then Op=01, A=8'h07, B=8'h05 -> Result=8'h02, Carry=0.
3. (PHASE_CHECK_EN) Arm, then apply Phase0 followed by Phase2 -> Phase_Err=1, Busy=0, Done never asserts, Result keeps its prior value. Next Start clears Phase_Err.
4. (PHASE_CHECK_EN) In ARMED, apply Phase0|Phase1=1 simultaneously -> Phase_Err=1, state IDLE.
5. Start with Op=11, A=8'hAA, B=8'h0F; assert Start again with A=8'h00 while Busy -> Result=8'hA5, Carry=0; exactly one Done pulse.
6. Drive Clear=0 in S2 of an ADD 8'hFF+8'h01 -> on the next edge Busy=0, Result=0, Carry=0, no Done. The following op runs normally.

Source files
------------

// File: rtl/phase_alu_sequencer.sv
// phase_alu_sequencer
//   Runs one ALU operation per full rotation of a 4-phase one-hot ring counter.
//   Phase0 arms the operation, Phase1 computes it, Phase2 writes the result
//   and Phase3 completes it.
//
// Build option:
//   PHASE_CHECK_EN  defined   -> every non-IDLE cycle checks the phase vector;
//                                a bad vector sets Phase_Err and aborts to IDLE.
//                   undefined -> ARMED advances on Phase0 alone, S1..S3 advance
//                                every cycle, Phase_Err stays 0.
//
// Ports:
//   Phase_Count  in   clock (rising edge)
//   Clear        in   synchronous active-low reset
//   Phase0..3    in   ring counter phases
//   Start        in   request, sampled only in IDLE
//   Op           in   2'b00 ADD, 2'b01 SUB, 2'b10 AND, 2'b11 XOR
//   Operand_A/B  in   operands, captured with Start
//   Busy         out  high from ARMED through S3
//   Done         out  one-cycle completion pulse
//   Result       out  registered result, held until the next write
//   Carry        out  ADD carry-out / SUB borrow / 0 for logic ops
//   Phase_Err    out  sticky phase-sequence error
//
// state | meaning
// IDLE  | waiting for Start, phases ignored
// ARMED | operands captured, waiting for Phase0
// S1    | Phase1 expected, compute into temp
// S2    | Phase2 expected, write temp to Result/Carry
// S3    | Phase3 expected, then IDLE with Done
module phase_alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             Phase_Count,
  input  logic             Clear,
  input  logic             Phase0,
  input  logic             Phase1,
  input  logic             Phase2,
  input  logic             Phase3,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Operand_A,
  input  logic [WIDTH-1:0] Operand_B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Phase_Err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_S1    = 3'd2,
    ST_S2    = 3'd3,
    ST_S3    = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             accept, err_set;
  logic             busy_nxt, done_nxt, err_nxt, load_tmp, load_res;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, tmp_res;
  logic             tmp_carry;
  logic [WIDTH:0]   alu;

`ifdef PHASE_CHECK_EN
  logic [3:0] phase_vec;
  logic       one_hot;
  assign phase_vec = {Phase3, Phase2, Phase1, Phase0};
  assign one_hot   = (phase_vec != 4'b0000) && ((phase_vec & (phase_vec - 4'd1)) == 4'b0000);
`else
  logic unused_phases;
  assign unused_phases = ^{Phase1, Phase2, Phase3};
`endif

  // Carry/borrow rides in the top bit so temp and Result load as one word.
  always_comb begin
    alu = '0;
    case (op_q)
      2'b00:   alu = {1'b0, a_q} + {1'b0, b_q};
      2'b01:   alu = {(a_q < b_q), a_q - b_q};
      2'b10:   alu = {1'b0, a_q & b_q};
      default: alu = {1'b0, a_q ^ b_q};
    endcase
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          state_nxt = ST_ARMED;
          accept    = 1'b1;
        end
      end
`ifdef PHASE_CHECK_EN
      // Another valid one-hot phase just means the ring has not reached Phase0 yet.
      ST_ARMED: begin
        if (!one_hot) begin
          state_nxt = ST_IDLE;
          err_set   = 1'b1;
        end else if (phase_vec == 4'b0001) begin
          state_nxt = ST_S1;
        end
      end
      ST_S1: begin
        if (phase_vec == 4'b0010) state_nxt = ST_S2;
        else begin
          state_nxt = ST_IDLE;
          err_set   = 1'b1;
        end
      end
      ST_S2: begin
        if (phase_vec == 4'b0100) state_nxt = ST_S3;
        else begin
          state_nxt = ST_IDLE;
          err_set   = 1'b1;
        end
      end
      ST_S3: begin
        state_nxt = ST_IDLE;
        if (phase_vec != 4'b1000) err_set = 1'b1;
      end
`else
      ST_ARMED: if (Phase0) state_nxt = ST_S1;
      ST_S1:    state_nxt = ST_S2;
      ST_S2:    state_nxt = ST_S3;
      ST_S3:    state_nxt = ST_IDLE;
`endif
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state == ST_S3) && (state_nxt == ST_IDLE) && !err_set;
    err_nxt  = Phase_Err;
    if (accept)       err_nxt = 1'b0;
    else if (err_set) err_nxt = 1'b1;
    load_tmp = (state == ST_S1) && (state_nxt == ST_S2);
    load_res = (state == ST_S2) && (state_nxt == ST_S3);
  end

  always_ff @(posedge Phase_Count) begin
    if (!Clear) begin
      state     <= ST_IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Phase_Err <= 1'b0;
      Result    <= '0;
      Carry     <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      tmp_res   <= '0;
      tmp_carry <= 1'b0;
    end else begin
      state     <= state_nxt;
      Busy      <= busy_nxt;
      Done      <= done_nxt;
      Phase_Err <= err_nxt;
      if (accept) begin
        op_q <= Op;
        a_q  <= Operand_A;
        b_q  <= Operand_B;
      end
      if (load_tmp) begin
        tmp_res   <= alu[WIDTH-1:0];
        tmp_carry <= alu[WIDTH];
      end
      if (load_res) begin
        Result <= tmp_res;
        Carry  <= tmp_carry;
      end
    end
  end

endmodule
